ps2_arrow_tracker: RTL and testbench



---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_arrow_decode.sv | 21 ++
 rtl/ps2_arrow_tracker.sv | 138 +++++++++++++
 tb/tb_ps2_arrow_tracker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key front end: FSM encodings, prefix bytes,
// keyboard response bytes and the four extended arrow scancodes.
package ps2_pkg;

  // Prefix-tracking FSM states
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

  localparam logic [7:0] ByteExt = 8'hE0;
  localparam logic [7:0] ByteBrk = 8'hF0;

  // Keyboard/controller responses that never start or complete a scancode
  localparam int unsigned NumResp = 7;
  localparam logic [7:0] RespBytes [NumResp] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  localparam logic [15:0] CodeLeft  = 16'hE06B;
  localparam logic [15:0] CodeDown  = 16'hE072;
  localparam logic [15:0] CodeRight = 16'hE074;
  localparam logic [15:0] CodeUp    = 16'hE075;

  function automatic logic is_response(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NumResp; i++) begin
      if (b == RespBytes[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_arrow_decode.sv
// Combinational arrow lookup: one-hot {left, down, right, up}, zero for other codes.
module ps2_arrow_decode
  import ps2_pkg::*;
(
  input  logic [15:0] i_code,
  output logic [3:0]  o_hit
);

  // Map a complete scancode onto its arrow position
  always_comb begin
    o_hit = 4'b0000;
    case (i_code)
      CodeLeft:  o_hit = 4'b1000;
      CodeDown:  o_hit = 4'b0100;
      CodeRight: o_hit = 4'b0010;
      CodeUp:    o_hit = 4'b0001;
      default:   o_hit = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ps2_arrow_tracker.sv
// PS/2 byte stream to scancode resolver with held state for the four arrow keys.
module ps2_arrow_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        code_valid,
  output logic [15:0] scancode,
  output logic        code_break,
  output logic        left,
  output logic        down,
  output logic        right,
  output logic        up,
  output logic        err_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [1:0]      r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_code_valid;
  logic [15:0]     r_scancode;
  logic            r_code_break;
  logic [3:0]      r_arrows;
  logic            r_err;

  logic [1:0]      w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_emit;
  logic            w_break;
  logic [15:0]     w_code;
  logic            w_timeout;
  logic [3:0]      w_hit;
  logic [3:0]      w_arrows_d;

  // Prefix FSM and idle counter; a byte always beats a simultaneous timeout
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_emit    = 1'b0;
    w_break   = 1'b0;
    w_code    = {8'h00, byte_in};
    w_timeout = 1'b0;
    if (byte_valid) begin
      w_cnt_d = '0;
      case (r_state)
        StIdle: begin
          if (byte_in == ByteExt) begin
            w_state_d = StExt;
          end else if (byte_in == ByteBrk) begin
            w_state_d = StBrk;
          end else if (!is_response(byte_in)) begin
            w_emit = 1'b1;
          end
        end
        StExt: begin
          if (byte_in == ByteBrk) begin
            w_state_d = StExtBrk;
          end else if (byte_in != ByteExt) begin
            w_emit    = 1'b1;
            w_code    = {ByteExt, byte_in};
            w_state_d = StIdle;
          end
        end
        StBrk: begin
          w_emit    = 1'b1;
          w_break   = 1'b1;
          w_state_d = StIdle;
        end
        default: begin
          w_emit    = 1'b1;
          w_break   = 1'b1;
          w_code    = {ByteExt, byte_in};
          w_state_d = StIdle;
        end
      endcase
    end else if (r_state != StIdle) begin
      if (r_cnt == CntMax) begin
        w_timeout = 1'b1;
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  ps2_arrow_decode u_decode (
    .i_code (w_code),
    .o_hit  (w_hit)
  );

  // Make sets the matching arrow, break clears it; other codes have zero hit
  always_comb begin
    w_arrows_d = r_arrows;
    if (w_emit) begin
      w_arrows_d = w_break ? (r_arrows & ~w_hit) : (r_arrows | w_hit);
    end
  end

  // State and output registers; scancode/code_break hold until the next code
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_code_valid <= 1'b0;
      r_scancode   <= 16'h0000;
      r_code_break <= 1'b0;
      r_arrows     <= 4'b0000;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_code_valid <= w_emit;
      r_err        <= w_timeout;
      r_arrows     <= w_arrows_d;
      if (w_emit) begin
        r_scancode   <= w_code;
        r_code_break <= w_break;
      end
    end
  end

  assign code_valid  = r_code_valid;
  assign scancode    = r_scancode;
  assign code_break  = r_code_break;
  assign left        = r_arrows[3];
  assign down        = r_arrows[2];
  assign right       = r_arrows[1];
  assign up          = r_arrows[0];
  assign err_timeout = r_err;

endmodule

// File: tb/tb_ps2_arrow_tracker.sv
// Directed bench for ps2_arrow_tracker with a scoreboard of expected codes.
module tb_ps2_arrow_tracker;

  logic        clk;
  logic        resetn;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        code_valid;
  logic [15:0] scancode;
  logic        code_break;
  logic        left, down, right, up;
  logic        err_timeout;

  int checks;
  int errors;
  int n_timeouts;
  logic [16:0] exp_q [$];

  ps2_arrow_tracker #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .code_valid  (code_valid),
    .scancode    (scancode),
    .code_break  (code_break),
    .left        (left),
    .down        (down),
    .right       (right),
    .up          (up),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one byte for one cycle; returns #1 after the sampling edge
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic brk, input logic [15:0] code);
    exp_q.push_back({brk, code});
  endtask

  // Scoreboard: every code_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (err_timeout) n_timeouts++;
    if (code_valid) begin
      chk("code_pending", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("scancode", {16'b0, scancode}, {16'b0, e[15:0]});
        chk("code_break", {31'b0, code_break}, {31'b0, e[16]});
      end
    end
  end

  function automatic logic [31:0] arrows();
    return {28'b0, left, down, right, up};
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    n_timeouts = 0;
    resetn     = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    idle(3);
    chk("reset_code_valid", {31'b0, code_valid}, 0);
    chk("reset_scancode", {16'b0, scancode}, 0);
    chk("reset_break", {31'b0, code_break}, 0);
    chk("reset_arrows", arrows(), 0);
    chk("reset_err", {31'b0, err_timeout}, 0);
    resetn = 1'b1;
    idle(1);

    // Left press and release
    send(8'hE0); push(1'b0, 16'hE06B); send(8'h6B);
    idle(1);
    chk("left_make", arrows(), 32'b1000);
    send(8'hE0); send(8'hF0); push(1'b1, 16'hE06B); send(8'h6B);
    idle(1);
    chk("left_break", arrows(), 32'b0000);

    // Right + up pressed, only right released
    send(8'hE0); push(1'b0, 16'hE074); send(8'h74);
    send(8'hE0); push(1'b0, 16'hE075); send(8'h75);
    idle(1);
    chk("right_up_held", arrows(), 32'b0011);
    send(8'hE0); send(8'hF0); push(1'b1, 16'hE074); send(8'h74);
    idle(1);
    chk("right_released", arrows(), 32'b0001);

    // Non-extended key, then responses discarded
    push(1'b0, 16'h001C); send(8'h1C);
    send(8'hF0); push(1'b1, 16'h001C); send(8'h1C);
    send(8'hAA); send(8'hFA);
    idle(3);
    chk("plain_key_arrows", arrows(), 32'b0001);
    chk("scancode_hold", {16'b0, scancode}, 32'h001C);
    chk("break_hold", {31'b0, code_break}, 1);

    // Timeout after a dangling E0
    send(8'hE0);
    idle(15);
    chk("timeout_not_yet", {31'b0, err_timeout}, 0);
    idle(1);
    chk("timeout_pulse", {31'b0, err_timeout}, 1);
    idle(1);
    chk("timeout_one_cycle", {31'b0, err_timeout}, 0);
    push(1'b0, 16'h0072); send(8'h72);
    idle(1);
    chk("after_timeout_down", arrows(), 32'b0001);

    // Back-to-back extended break for up
    send(8'hE0); send(8'hF0); push(1'b1, 16'hE075); send(8'h75);
    idle(1);
    chk("up_cleared", arrows(), 32'b0000);

    // Reset in the middle of a code, with a byte in the same cycle
    send(8'hE0); push(1'b0, 16'hE06B); send(8'h6B);
    send(8'hE0);
    resetn = 1'b0;
    send(8'h75);
    chk("midreset_arrows", arrows(), 0);
    chk("midreset_code_valid", {31'b0, code_valid}, 0);
    chk("midreset_scancode", {16'b0, scancode}, 0);
    resetn = 1'b1;
    push(1'b0, 16'h0075); send(8'h75);
    idle(1);
    chk("prefix_discarded", arrows(), 0);

    // Typematic repeats of down
    for (int i = 0; i < 3; i++) begin
      send(8'hE0); push(1'b0, 16'hE072); send(8'h72);
    end
    idle(1);
    chk("typematic_down", arrows(), 32'b0100);

    // Byte arriving on the expiry cycle wins
    send(8'hE0);
    idle(15);
    push(1'b1, 16'hE072);
    send(8'hF0);
    idle(1);
    chk("race_no_err", {31'b0, err_timeout}, 0);
    send(8'h72);
    idle(1);
    chk("race_down_released", arrows(), 0);

    // Pause prefix E1 is an ordinary byte
    push(1'b0, 16'h00E1); send(8'hE1);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("timeout_count", n_timeouts, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
